// File: rtl/banner_pkg.sv
// Shared types and geometry for the status-banner scheduler.
// Banner sits at a fixed 80x45 window; offsets into the sprite ROM are 12 bits wide.
package banner_pkg;

    typedef enum logic [1:0] {
        MSG_CHECK = 2'd0,
        MSG_MATE  = 2'd1,
        MSG_STALE = 2'd2,
        MSG_TURN  = 2'd3
    } msg_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        STICKY = 2'd2
    } state_e;

    localparam int X0      = 560;
    localparam int Y0      = 434;
    localparam int W       = 80;
    localparam int H       = 45;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int OFF_W   = 12;

    // Fixed priority: checkmate, stalemate, check, turn.
    function automatic msg_e pick_msg(input logic [3:0] req);
        if (req[1])      return MSG_MATE;
        else if (req[2]) return MSG_STALE;
        else if (req[0]) return MSG_CHECK;
        else             return MSG_TURN;
    endfunction

endpackage

// File: rtl/banner_scheduler_if.sv
// Pixel-position, request and ROM-address signals between game logic, the
// scheduler and the pixel mux.
interface banner_scheduler_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic [3:0]  req;
    logic        clear;
    logic        banner_on;
    logic [1:0]  msg_id;
    logic [13:0] rom_address;
    logic        busy;

    modport master (
        output DrawX, DrawY, blank, req, clear,
        input  banner_on, msg_id, rom_address, busy
    );

    modport slave (
        input  DrawX, DrawY, blank, req, clear,
        output banner_on, msg_id, rom_address, busy
    );
endinterface

// File: rtl/banner_addr_gen.sv
// Banner window hit test and ROM address generation, registered once so the
// outputs for a pixel appear on the clock after that pixel is presented.
module banner_addr_gen
    import banner_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank,
    input  logic        show,
    input  logic [1:0]  msg_id,
    output logic        banner_on,
    output logic [13:0] rom_address
);

    logic             in_x;
    logic             in_y;
    logic             in_region;
    logic [OFF_W-1:0] dx;
    logic [OFF_W-1:0] dy;
    logic [OFF_W-1:0] offset;
    logic             banner_on_reg;
    logic [13:0]      rom_address_reg;

    assign in_x      = (draw_x >= 10'(X0)) && (draw_x <= 10'(X0 + W - 1));
    assign in_y      = (draw_y >= 10'(Y0)) && (draw_y <= 10'(Y0 + H - 1));
    assign in_region = in_x && in_y;

    // Row stride of 80 built as 64 + 16; values outside the window are masked below.
    assign dx     = OFF_W'(draw_x) - OFF_W'(X0);
    assign dy     = OFF_W'(draw_y) - OFF_W'(Y0);
    assign offset = dx + (dy << 6) + (dy << 4);

    always_ff @(posedge clk) begin
        if (srst) begin
            banner_on_reg   <= 1'b0;
            rom_address_reg <= '0;
        end else begin
            banner_on_reg   <= in_region && blank && show;
            rom_address_reg <= in_region ? {msg_id, offset} : 14'd0;
        end
    end

    assign banner_on   = banner_on_reg;
    assign rom_address = rom_address_reg;

endmodule

// File: rtl/banner_scheduler.sv
// Picks one banner message per frame, holds it for a minimum time, latches
// terminal messages until cleared, blinks the check banner and drives the ROM address.
module banner_scheduler
    import banner_pkg::*;
#(
    parameter int MIN_FRAMES   = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             vga_clk,
    input  logic             reset,
    banner_scheduler_if.slave bus
);

    localparam int CW = (MIN_FRAMES > 0) ? $clog2(MIN_FRAMES + 1) : 1;
    localparam int BW = (BLINK_FRAMES > 0) ? $clog2(2 * BLINK_FRAMES) : 1;

    state_e        state_reg;
    state_e        state_next;
    msg_e          msg_reg;
    msg_e          msg_next;
    logic [CW-1:0] frame_cnt_reg;
    logic [CW-1:0] frame_cnt_next;
    logic [BW-1:0] blink_cnt_reg;
    logic [BW-1:0] blink_cnt_next;

    logic frame_tick;
    logic any_req;
    logic cnt_full;
    logic busy;
    logic blink_visible;
    msg_e top_msg;

    assign frame_tick = (bus.DrawX == 10'(H_TOTAL - 1)) && (bus.DrawY == 10'(V_TOTAL - 1));
    assign any_req    = |bus.req;
    assign top_msg    = pick_msg(bus.req);
    assign cnt_full   = int'(frame_cnt_reg) >= MIN_FRAMES;
    assign busy       = (state_reg != IDLE);

    assign blink_visible = (BLINK_FRAMES == 0) || (msg_reg != MSG_CHECK) ||
                           (int'(blink_cnt_reg) < BLINK_FRAMES);

    always_comb begin
        state_next     = state_reg;
        msg_next       = msg_reg;
        frame_cnt_next = frame_cnt_reg;
        blink_cnt_next = blink_cnt_reg;

        // clear beats a coincident frame_tick; live requests re-latch on the next tick
        if (bus.clear) begin
            state_next     = IDLE;
            msg_next       = MSG_CHECK;
            frame_cnt_next = '0;
            blink_cnt_next = '0;
        end else if (frame_tick) begin
            if (state_reg != IDLE) begin
                if (int'(blink_cnt_reg) == 2 * BLINK_FRAMES - 1) blink_cnt_next = '0;
                else                                             blink_cnt_next = blink_cnt_reg + BW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_next     = SHOW;
                        msg_next       = top_msg;
                        frame_cnt_next = '0;
                        blink_cnt_next = '0;
                    end
                end
                SHOW: begin
                    if (!cnt_full) begin
                        frame_cnt_next = frame_cnt_reg + CW'(1);
                    end else if (msg_reg == MSG_MATE || msg_reg == MSG_STALE) begin
                        state_next = STICKY;
                    end else if (!any_req) begin
                        state_next     = IDLE;
                        msg_next       = MSG_CHECK;
                        frame_cnt_next = '0;
                        blink_cnt_next = '0;
                    end else if (top_msg != msg_reg) begin
                        // either a higher-priority request or the latched one was dropped
                        msg_next       = top_msg;
                        frame_cnt_next = '0;
                        blink_cnt_next = '0;
                    end
                end
                STICKY: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            msg_reg       <= MSG_CHECK;
            frame_cnt_reg <= '0;
            blink_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            msg_reg       <= msg_next;
            frame_cnt_reg <= frame_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
        end
    end

    assign bus.busy   = busy;
    assign bus.msg_id = msg_reg;

    banner_addr_gen u_addr_gen (
        .clk         (vga_clk),
        .srst        (reset),
        .draw_x      (bus.DrawX),
        .draw_y      (bus.DrawY),
        .blank       (bus.blank),
        .show        (busy && blink_visible),
        .msg_id      (msg_reg),
        .banner_on   (bus.banner_on),
        .rom_address (bus.rom_address)
    );

endmodule

// File: tb/tb_banner_scheduler.sv
// Scenario bench for banner_scheduler: frame ticks are produced by driving the
// last pixel position directly, so each frame costs only a few clocks.
module tb_banner_scheduler;

    logic vga_clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    typedef struct {
        string       name;
        logic        on;
        logic [13:0] addr;
        bit          chk_addr;
    } pix_t;

    pix_t sb[$];

    banner_scheduler_if bus ();

    banner_scheduler #(
        .MIN_FRAMES   (60),
        .BLINK_FRAMES (30)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic tick();
        bus.DrawX = 10'd799;
        bus.DrawY = 10'd524;
        step();
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Drive a pixel and queue the output expected one clock later.
    task automatic drive_pix(input int x, input int y, input bit b, input bit show,
                             input int msg, input bit chk_addr, input string name);
        pix_t p;
        bit   in;
        in         = (x >= 560) && (x <= 639) && (y >= 434) && (y <= 478);
        p.name     = name;
        p.on       = in && b && show;
        p.addr     = in ? 14'(msg * 4096 + (x - 560) + (y - 434) * 80) : 14'd0;
        p.chk_addr = chk_addr;
        bus.DrawX  = 10'(x);
        bus.DrawY  = 10'(y);
        bus.blank  = b;
        sb.push_back(p);
    endtask

    task automatic test_reset();
        pix_t e;
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.banner_on !== 1'b0 || bus.msg_id !== 2'd0 || bus.rom_address !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_init: busy=%b on=%b msg=%0d addr=%h expected all 0",
                     bus.busy, bus.banner_on, bus.msg_id, bus.rom_address);
        end
        reset   = 1'b0;
        bus.req = 4'b0001;
        tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: busy=%b expected 1", bus.busy);
        end
        // assert reset mid-frame while a visible region pixel is presented
        drive_pix(600, 440, 1'b1, 1'b0, 0, 1'b0, "reset_mid");
        reset = 1'b1;
        repeat (3) step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on || bus.rom_address !== 14'd0 || bus.busy !== 1'b0 || bus.msg_id !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: on=%b addr=%h busy=%b msg=%0d expected 0/0/0/0",
                     e.name, bus.banner_on, bus.rom_address, bus.busy, bus.msg_id);
        end
        reset   = 1'b0;
        bus.req = 4'b0000;
    endtask

    task automatic test_check_latch();
        pix_t e;
        bus.req = 4'b0001;
        drive_pix(560, 434, 1'b1, 1'b0, 0, 1'b1, "pre_tick_pixel");
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on || bus.rom_address !== e.addr || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: on=%b addr=%h busy=%b expected on=%b addr=%h busy=0",
                     e.name, bus.banner_on, bus.rom_address, bus.busy, e.on, e.addr);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.msg_id !== 2'd0) begin
            n_fail++;
            $display("FAIL latch_check: busy=%b msg=%0d expected busy=1 msg=0", bus.busy, bus.msg_id);
        end
        drive_pix(560, 434, 1'b1, 1'b1, 0, 1'b1, "corner_tl");
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on || bus.rom_address !== e.addr) begin
            n_fail++;
            $display("FAIL %s: on=%b addr=%h expected on=%b addr=%h", e.name, bus.banner_on, bus.rom_address, e.on, e.addr);
        end
        drive_pix(639, 478, 1'b1, 1'b1, 0, 1'b1, "corner_br");
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on || bus.rom_address !== e.addr) begin
            n_fail++;
            $display("FAIL %s: on=%b addr=%h expected on=%b addr=%h", e.name, bus.banner_on, bus.rom_address, e.on, e.addr);
        end
    endtask

    task automatic test_edges();
        int   xs [6] = '{559, 640, 560, 560, 600, 561};
        int   ys [6] = '{434, 434, 433, 479, 450, 435};
        bit   bs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        pix_t e;
        for (int i = 0; i < 6; i++) begin
            drive_pix(xs[i], ys[i], bs[i], 1'b1, 0, 1'b1, $sformatf("edge_%0d_%0d_b%0d", xs[i], ys[i], bs[i]));
            step();
            e = sb.pop_front();
            n_checks++;
            if (bus.banner_on !== e.on || bus.rom_address !== e.addr) begin
                n_fail++;
                $display("FAIL %s: on=%b addr=%h expected on=%b addr=%h", e.name, bus.banner_on, bus.rom_address, e.on, e.addr);
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] reqs [4] = '{4'b1111, 4'b1101, 4'b1001, 4'b1000};
        logic [1:0] exps [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
        for (int i = 0; i < 4; i++) begin
            bus.req = reqs[i];
            pulse_clear();
            tick();
            n_checks++;
            if (bus.busy !== 1'b1 || bus.msg_id !== exps[i]) begin
                n_fail++;
                $display("FAIL prio_%b: busy=%b msg=%0d expected busy=1 msg=%0d", reqs[i], bus.busy, bus.msg_id, exps[i]);
            end
        end
    endtask

    task automatic test_preempt();
        pix_t       e;
        logic [1:0] exp_msg;
        bus.req = 4'b0001;
        pulse_clear();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL preempt_clear: busy=%b expected 0", bus.busy);
        end
        tick();
        for (int k = 1; k <= 61; k++) begin
            if (k == 10) bus.req = 4'b0011;
            tick();
            exp_msg = (k <= 60) ? 2'd0 : 2'd1;
            n_checks++;
            if (bus.msg_id !== exp_msg || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL preempt_tick%0d: msg=%0d busy=%b expected msg=%0d busy=1", k, bus.msg_id, bus.busy, exp_msg);
            end
        end
        repeat (61) tick();
        bus.req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus.msg_id !== 2'd1 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sticky_mate_%0d: msg=%0d busy=%b expected msg=1 busy=1", k, bus.msg_id, bus.busy);
            end
        end
        drive_pix(560, 434, 1'b1, 1'b1, 1, 1'b1, "sticky_mate_pixel");
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on || bus.rom_address !== e.addr) begin
            n_fail++;
            $display("FAIL %s: on=%b addr=%h expected on=%b addr=%h", e.name, bus.banner_on, bus.rom_address, e.on, e.addr);
        end
    endtask

    task automatic test_clear();
        pix_t e;
        bus.req = 4'b0100;
        pulse_clear();
        tick();
        repeat (61) tick();
        bus.req = 4'b0000;
        repeat (2) tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.msg_id !== 2'd2) begin
            n_fail++;
            $display("FAIL sticky_stale: busy=%b msg=%0d expected busy=1 msg=2", bus.busy, bus.msg_id);
        end
        // clear coincides with frame_tick and a live request
        bus.req   = 4'b0100;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_wins: busy=%b expected 0", bus.busy);
        end
        drive_pix(600, 440, 1'b1, 1'b0, 0, 1'b0, "after_clear_pixel");
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on) begin
            n_fail++;
            $display("FAIL %s: on=%b expected on=%b", e.name, bus.banner_on, e.on);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.msg_id !== 2'd2) begin
            n_fail++;
            $display("FAIL relatch_stale: busy=%b msg=%0d expected busy=1 msg=2", bus.busy, bus.msg_id);
        end
        drive_pix(600, 440, 1'b1, 1'b1, 2, 1'b1, "relatch_pixel");
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.banner_on !== e.on || bus.rom_address !== e.addr) begin
            n_fail++;
            $display("FAIL %s: on=%b addr=%h expected on=%b addr=%h", e.name, bus.banner_on, bus.rom_address, e.on, e.addr);
        end
    endtask

    task automatic test_blink();
        pix_t e;
        bus.req = 4'b0001;
        pulse_clear();
        tick();
        for (int f = 0; f <= 70; f++) begin
            // a dropped request while still locked must be ignored
            bus.req = (f == 20) ? 4'b0000 : 4'b0001;
            drive_pix(560, 434, 1'b1, ((f % 60) < 30), 0, 1'b1, $sformatf("blink_f%0d", f));
            step();
            e = sb.pop_front();
            n_checks++;
            if (bus.banner_on !== e.on || bus.rom_address !== e.addr || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s: on=%b addr=%h busy=%b expected on=%b addr=%h busy=1",
                         e.name, bus.banner_on, bus.rom_address, bus.busy, e.on, e.addr);
            end
            tick();
        end
        bus.req = 4'b0000;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_drop_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.blank = 1'b1;
        bus.req   = 4'b0000;
        bus.clear = 1'b0;
        test_reset();
        test_check_latch();
        test_edges();
        test_priority();
        test_preempt();
        test_clear();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
